// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, single-outstanding SRAM-like request, one-entry decode slot.
// Define FETCH_ALIGN_CHECK_EN to raise if_adel for a misaligned PC instead of fetching it.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ex_flush,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        cancel_reg, cancel_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_inst_reg, if_inst_next;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_adel_reg, if_adel_next;
`endif

  logic        redirect;
  logic [31:0] redirect_target;
  logic        slot_free;
  logic        misaligned;
  logic        req_c;
  logic        accept;

  assign redirect        = ex_flush | redirect_valid;
  assign redirect_target = ex_flush ? EXC_VECTOR : redirect_pc;
  assign slot_free       = !if_valid_reg || id_allowin;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned      = (pc_reg[1:0] != 2'b00);
`else
  assign misaligned      = 1'b0;
`endif
  assign req_c           = (state_reg == S_REQ) && slot_free && !misaligned;
  assign accept          = req_c && inst_addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      cancel_reg   <= 1'b0;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_inst_reg  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      if_adel_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      cancel_reg   <= cancel_next;
      if_valid_reg <= if_valid_next;
      if_pc_reg    <= if_pc_next;
      if_inst_reg  <= if_inst_next;
`ifdef FETCH_ALIGN_CHECK_EN
      if_adel_reg  <= if_adel_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    cancel_next   = cancel_reg;
    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_inst_next  = if_inst_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    if_adel_next  = if_adel_reg;
`endif

    if (if_valid_reg && id_allowin)
      if_valid_next = 1'b0;

    case (state_reg)
      S_REQ: begin
        if (accept)
          state_next = S_WAIT;
`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC parks here, re-presenting the fault until redirected.
        if (misaligned && slot_free && !redirect) begin
          if_valid_next = 1'b1;
          if_pc_next    = pc_reg;
          if_inst_next  = 32'h0;
          if_adel_next  = 1'b1;
        end
`endif
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_next  = S_REQ;
          cancel_next = 1'b0;
          if (!cancel_reg && !redirect) begin
            if_valid_next = 1'b1;
            if_pc_next    = pc_reg;
            if_inst_next  = inst_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
            if_adel_next  = 1'b0;
`endif
            pc_next       = pc_reg + 32'd4;
          end
        end
      end
      default: state_next = S_REQ;
    endcase

    // A redirect leaves a response in flight unless it returns this very cycle.
    if (redirect) begin
      pc_next       = redirect_target;
      if_valid_next = 1'b0;
      if (((state_reg == S_WAIT) && !inst_data_ok) || accept)
        cancel_next = 1'b1;
    end
  end

  assign inst_req  = req_c;
  assign inst_addr = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc     = if_pc_reg;
  assign if_pc_4   = if_pc_reg + 32'd4;
  assign if_inst   = if_inst_reg;
`ifdef FETCH_ALIGN_CHECK_EN
  assign if_adel   = if_adel_reg;
`else
  assign if_adel   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, fetch/hold, redirect cancel, flush priority, wrap, alignment.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ex_flush;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic [31:0] if_inst;
  logic        if_adel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ex_flush       (ex_flush),
    .id_allowin     (id_allowin),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_4        (if_pc_4),
    .if_inst        (if_inst),
    .if_adel        (if_adel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; ex_flush = 1'b0; id_allowin = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_adel", {31'd0, if_adel}, 32'd0);
    chk("rst_req", {31'd0, inst_req}, 32'd1);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);

    // 1: first fetch
    resetn = 1'b1; inst_addr_ok = 1'b1;
    #1 chk("t1_addr", inst_addr, 32'hBFC0_0000);
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; id_allowin = 1'b0;
    #1 chk("t1_wait_req", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc", if_pc, 32'hBFC0_0000);
    chk("t1_pc4", if_pc_4, 32'hBFC0_0004);
    chk("t1_inst", if_inst, 32'h2408_0001);

    // 2: decode stalled for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("t2_req", {31'd0, inst_req}, 32'd0);
      chk("t2_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_inst", if_inst, 32'h2408_0001);
      chk("t2_pc", if_pc, 32'hBFC0_0000);
      tick();
    end
    id_allowin = 1'b1; inst_addr_ok = 1'b1;
    #1 chk("t2_req_go", {31'd0, inst_req}, 32'd1);
    chk("t2_addr_go", inst_addr, 32'hBFC0_0004);
    tick();
    inst_addr_ok = 1'b0;
    chk("t2_consumed", {31'd0, if_valid}, 32'd0);

    // 3: redirect while waiting, late data discarded
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    #1 chk("t3_wait_req", {31'd0, inst_req}, 32'd0);
    tick(); tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    chk("t3_valid", {31'd0, if_valid}, 32'd0);
    #1 chk("t3_req", {31'd0, inst_req}, 32'd1);
    chk("t3_addr", inst_addr, 32'h8000_1000);

    // 4: flush beats redirect
    ex_flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h9000_0000;
    tick();
    ex_flush = 1'b0; redirect_valid = 1'b0;
    #1 chk("t4_addr", inst_addr, 32'h8000_0180);
    chk("t4_valid", {31'd0, if_valid}, 32'd0);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    tick();
    inst_data_ok = 1'b0;
    chk("t4_fill_pc", if_pc, 32'h8000_0180);
    chk("t4_fill_inst", if_inst, 32'h1111_2222);
    chk("t4_fill_valid", {31'd0, if_valid}, 32'd1);
    chk("t4_next_addr", inst_addr, 32'h8000_0184);
    chk("t4_next_req", {31'd0, inst_req}, 32'd1);

    // redirect coinciding with an accepted request: its response must be dropped
    redirect_valid = 1'b1; redirect_pc = 32'hA000_0000; inst_addr_ok = 1'b1;
    tick();
    redirect_valid = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h7777_7777;
    tick();
    inst_data_ok = 1'b0;
    chk("rc_valid", {31'd0, if_valid}, 32'd0);
    chk("rc_addr", inst_addr, 32'hA000_0000);

    // redirect coinciding with data return: word dropped, no cancel left behind
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8888_8888;
    redirect_valid = 1'b1; redirect_pc = 32'hB000_0000;
    tick();
    inst_data_ok = 1'b0; redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, if_valid}, 32'd0);
    chk("rd_addr", inst_addr, 32'hB000_0000);
    chk("rd_req", {31'd0, inst_req}, 32'd1);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_6666;
    tick();
    inst_data_ok = 1'b0;
    chk("rd_fill_valid", {31'd0, if_valid}, 32'd1);
    chk("rd_fill_pc", if_pc, 32'hB000_0000);
    chk("rd_fill_inst", if_inst, 32'h5555_6666);

    // 5: PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr", inst_addr, 32'hFFFF_FFFC);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_4444; id_allowin = 1'b0;
    tick();
    inst_data_ok = 1'b0;
    chk("t5_pc", if_pc, 32'hFFFF_FFFC);
    chk("t5_pc4", if_pc_4, 32'h0000_0000);
    chk("t5_inst", if_inst, 32'h3333_4444);
    chk("t5_hold_req", {31'd0, inst_req}, 32'd0);
    id_allowin = 1'b1;
    #1 chk("t5_next_addr", inst_addr, 32'h0000_0000);
    chk("t5_next_req", {31'd0, inst_req}, 32'd1);

    // 6: misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    #1 chk("t6_req0", {31'd0, inst_req}, 32'd0);
    tick();
    chk("t6_req1", {31'd0, inst_req}, 32'd0);
    chk("t6_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_adel", {31'd0, if_adel}, 32'd1);
    chk("t6_pc", if_pc, 32'h8000_0002);
    chk("t6_inst", if_inst, 32'h0);
`else
    #1 chk("t6_req", {31'd0, inst_req}, 32'd1);
    chk("t6_addr", inst_addr, 32'h8000_0002);
    chk("t6_adel", {31'd0, if_adel}, 32'd0);
`endif

    // reset in the middle of a transaction
    redirect_valid = 1'b1; redirect_pc = 32'hC000_0000;
    tick();
    redirect_valid = 1'b0; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mr_valid", {31'd0, if_valid}, 32'd0);
    chk("mr_addr", inst_addr, 32'hBFC0_0000);
    chk("mr_req", {31'd0, inst_req}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
